// File: rtl/perf_monitor_pkg.sv
// rtl/perf_monitor_pkg.sv - shared state encoding and readout select constants for perf_monitor
package perf_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RUN          = 3'd1,
    ST_DONE_PASS    = 3'd2,
    ST_DONE_FAIL    = 3'd3,
    ST_DONE_TIMEOUT = 3'd4
  } state_e;

  localparam logic [1:0] WORD_MODE_DEFAULT = 2'b10;

  localparam int SEL_CYCLES  = 0;
  localparam int SEL_RETIRED = 1;
  localparam int SEL_EVT0    = 2;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - saturating up-counter with synchronous clear
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - run-control FSM snooping a PASS/FAIL flag store, with cycle/retire/event counters
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int                    CNT_W          = 32,
  parameter int                    DATA_W         = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    N_EVT          = 4,
  parameter logic [ADDR_WIDTH-1:0] PASS_ADDR      = 8'h08,
  parameter logic [DATA_W-1:0]     PASS_VAL       = 32'h1,
  parameter logic [1:0]            WORD_MODE      = WORD_MODE_DEFAULT,
  parameter int                    TIMEOUT_CYCLES = 50000,
  localparam int                   SEL_W          = $clog2(N_EVT + 2)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  retire,
  input  logic [N_EVT-1:0]      evt,
  input  logic                  bus_wr_en,
  input  logic [ADDR_WIDTH-1:0] bus_wr_addr,
  input  logic [DATA_W-1:0]     bus_wr_data,
  input  logic [1:0]            bus_mode,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_W-1:0]      rd_data,
  output logic [2:0]            state,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      cycles,
  output logic [CNT_W-1:0]      retired
);

  localparam int N_CNT = N_EVT + 2;
  // Compare in a wide domain so a narrow counter cannot alias the limit.
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES - 1);

  state_e st;
  logic   running;
  logic   clr;
  logic   flag_hit;
  logic   at_limit;
  logic [N_CNT-1:0] inc;
  logic [CNT_W-1:0] cnt [N_CNT];
  logic [CNT_W-1:0] rd_next;

  assign running  = (st == ST_RUN);
  assign clr      = start && !running;
  assign flag_hit = running && bus_wr_en && (bus_wr_addr == PASS_ADDR) && (bus_mode == WORD_MODE);
  assign at_limit = (64'(cnt[SEL_CYCLES]) == TO_LAST);

  assign inc[SEL_CYCLES]          = running;
  assign inc[SEL_RETIRED]         = running && retire;
  assign inc[N_CNT-1:SEL_EVT0]    = evt & {N_EVT{running}};

  for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clr),
      .inc   (inc[i]),
      .count (cnt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_RUN: begin
          if (flag_hit) begin
            st <= (bus_wr_data == PASS_VAL) ? ST_DONE_PASS : ST_DONE_FAIL;
          end else if (at_limit) begin
            st <= ST_DONE_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            st <= ST_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_next = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

  assign state   = st;
  assign done    = (st == ST_DONE_PASS) || (st == ST_DONE_FAIL) || (st == ST_DONE_TIMEOUT);
  assign pass    = (st == ST_DONE_PASS);
  assign cycles  = cnt[SEL_CYCLES];
  assign retired = cnt[SEL_RETIRED];

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - scoreboard bench for perf_monitor
module tb_perf_monitor;

  localparam int TO = 20;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        n_rst, start, retire, bus_wr_en;
  logic [3:0]  evt;
  logic [7:0]  bus_wr_addr;
  logic [31:0] bus_wr_data;
  logic [1:0]  bus_mode;
  logic [2:0]  rd_sel;

  logic [31:0] rd_data, cycles, retired;
  logic [2:0]  state;
  logic        done, pass;

  logic [3:0]  s_rd_data, s_cycles, s_retired;
  logic [2:0]  s_state;
  logic        s_done, s_pass;

  always #5 clk = ~clk;

  perf_monitor #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .retire(retire), .evt(evt),
    .bus_wr_en(bus_wr_en), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .bus_mode(bus_mode), .rd_sel(rd_sel), .rd_data(rd_data), .state(state),
    .done(done), .pass(pass), .cycles(cycles), .retired(retired)
  );

  perf_monitor #(.CNT_W(4)) dut_small (
    .clk(clk), .n_rst(n_rst), .start(start), .retire(retire), .evt(evt),
    .bus_wr_en(bus_wr_en), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .bus_mode(bus_mode), .rd_sel(rd_sel), .rd_data(s_rd_data), .state(s_state),
    .done(s_done), .pass(s_pass), .cycles(s_cycles), .retired(s_retired)
  );

  typedef struct {
    int     st;
    longint cyc;
    longint ret;
    longint rd;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     m_state = 0;
  longint m_cnt[6];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_inc(input longint v);
    return (v < MAX32) ? v + 1 : v;
  endfunction

  // Predict the edge from the driven inputs, push it, then compare after the edge.
  task automatic step();
    exp_t   e;
    exp_t   got;
    longint c[6];
    bit     hit;
    int     ns;
    c   = m_cnt;
    hit = (m_state == 1) && bus_wr_en && (bus_wr_addr == 8'h08) && (bus_mode == 2'b10);
    ns  = m_state;
    if (!n_rst) begin
      ns = 0;
      foreach (c[i]) c[i] = 0;
      e.rd = 0;
    end else begin
      e.rd = (rd_sel < 6) ? m_cnt[rd_sel] : 0;
      if (m_state != 1) begin
        if (start) begin
          ns = 1;
          foreach (c[i]) c[i] = 0;
        end
      end else begin
        c[0] = sat_inc(c[0]);
        if (retire) c[1] = sat_inc(c[1]);
        for (int k = 0; k < 4; k++) if (evt[k]) c[2+k] = sat_inc(c[2+k]);
        if (hit) ns = (bus_wr_data == 32'h1) ? 2 : 3;
        else if (m_cnt[0] == TO - 1) ns = 4;
      end
    end
    m_state = ns;
    m_cnt   = c;
    e.st  = ns;
    e.cyc = c[0];
    e.ret = c[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("state",   64'(state),   64'(got.st));
    check("cycles",  64'(cycles),  64'(got.cyc));
    check("retired", 64'(retired), 64'(got.ret));
    check("rd_data", 64'(rd_data), 64'(got.rd));
    check("done",    64'(done),    64'(got.st >= 2));
    check("pass",    64'(pass),    64'(got.st == 2));
  endtask

  task automatic flag_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] m);
    bus_wr_en = 1'b1; bus_wr_addr = a; bus_wr_data = d; bus_mode = m;
    step();
    bus_wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; retire = 1'b0; evt = '0; bus_wr_en = 1'b0;
    bus_wr_addr = '0; bus_wr_data = '0; bus_mode = '0; rd_sel = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    #1;
    step();
    step();
    check("reset_state", 64'(state), 64'd0);
    n_rst = 1'b1;
    step();

    // Normal pass run with random traffic and an ignored start mid-run
    do_start();
    for (int i = 0; i < 10; i++) begin
      retire = 1'($urandom_range(0, 1));
      evt    = 4'($urandom);
      rd_sel = 3'($urandom_range(0, 7));
      start  = (i == 4);
      step();
    end
    start = 1'b0;
    retire = 1'b1;
    flag_write(8'h08, 32'h1, 2'b10);
    check("pass_state", 64'(state), 64'd2);
    check("pass_cycles", 64'(cycles), 64'd11);
    retire = 1'b0;
    step();
    step();

    // Fail run
    do_start();
    for (int i = 0; i < 3; i++) step();
    flag_write(8'h08, 32'h5, 2'b10);
    check("fail_state", 64'(state), 64'd3);
    check("fail_done", 64'(done), 64'd1);
    check("fail_pass", 64'(pass), 64'd0);

    // Ignored writes, then timeout
    do_start();
    flag_write(8'h08, 32'h1, 2'b00);
    flag_write(8'h0C, 32'h1, 2'b10);
    check("ignore_state", 64'(state), 64'd1);
    for (int i = 0; i < 40 && state != 3'd4; i++) step();
    check("timeout_state", 64'(state), 64'd4);
    check("timeout_cycles", 64'(cycles), 64'(TO));
    step();

    // Flag hit on the timeout edge wins
    do_start();
    for (int i = 0; i < TO - 1; i++) step();
    flag_write(8'h08, 32'h1, 2'b10);
    check("edge_hit_state", 64'(state), 64'd2);
    check("edge_hit_cycles", 64'(cycles), 64'(TO));

    // evt[1] readout through rd_sel=3
    do_start();
    evt = 4'b0010;
    for (int i = 0; i < 5; i++) step();
    evt = '0;
    rd_sel = 3'd3;
    step();
    check("evt1_rd", 64'(rd_data), 64'd5);
    rd_sel = 3'd7;
    step();
    check("rd_oob", 64'(rd_data), 64'd0);

    // Reset mid-run beats start and a flag hit
    do_start();
    retire = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_rst = 1'b0;
    start = 1'b1;
    flag_write(8'h08, 32'h1, 2'b10);
    check("rst_state", 64'(state), 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    n_rst = 1'b1;
    start = 1'b0;
    step();

    // Narrow counters saturate; narrow instance must not alias the timeout
    do_start();
    retire = 1'b1;
    for (int i = 0; i < 20; i++) step();
    retire = 1'b0;
    check("small_retired", 64'(s_retired), 64'hF);
    check("small_cycles", 64'(s_cycles), 64'hF);
    check("small_state", 64'(s_state), 64'd1);
    check("small_done", 64'(s_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
